dataio_spi_master: RTL

SPI initiator for the data_io file-download protocol: the host-controller end of the link whose receiver sits behind `SPI_SS2` in the core. It turns a local byte stream into a complete download transaction: index select, download start, data burst, download end. It drives `spi_sck`, `spi_mosi` and `spi_ss_n` in SPI mode 0, MSB first. It is used as the stimulus generator in core-level simulation, and on boards with no controller to preload a ROM from local flash.

---
 rtl/dataio_pkg.sv | 49 ++++
 rtl/spi_byte_tx.sv | 72 +++++++
 rtl/dataio_spi_master.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/dataio_pkg.sv
// Shared constants, FSM state type and small decode helpers for the data_io SPI initiator.
package dataio_pkg;

    localparam logic [7:0] UIO_FILE_TX     = 8'h53;
    localparam logic [7:0] UIO_FILE_TX_DAT = 8'h54;
    localparam logic [7:0] UIO_FILE_INDEX  = 8'h55;
    localparam logic [7:0] ARG_START       = 8'hFF;
    localparam logic [7:0] ARG_END         = 8'h00;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEL1,
        ST_IDX,
        ST_GAP,
        ST_SEL2,
        ST_STA,
        ST_SEL3,
        ST_DAT,
        ST_SEL4,
        ST_END,
        ST_DONE
    } state_e;

    function automatic logic [7:0] sel_cmd(input state_e s);
        case (s)
            ST_SEL1: return UIO_FILE_INDEX;
            ST_SEL3: return UIO_FILE_TX_DAT;
            default: return UIO_FILE_TX;
        endcase
    endfunction

    function automatic state_e sel_next(input state_e s);
        case (s)
            ST_SEL1: return ST_IDX;
            ST_SEL2: return ST_STA;
            ST_SEL3: return ST_DAT;
            default: return ST_END;
        endcase
    endfunction

    function automatic state_e gap_next(input state_e s);
        case (s)
            ST_IDX:  return ST_SEL2;
            ST_STA:  return ST_SEL3;
            default: return ST_SEL4;
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// Mode-0 MSB-first byte shifter: one load pulse produces exactly 16*CLK_DIV clk cycles of SCK activity.
module spi_byte_tx
    import dataio_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       sck,
    output logic       mosi,
    output logic       idle
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic          active_q;
    logic          sck_q;
    logic          mosi_q;
    logic [DW-1:0] div_q;
    logic [2:0]    bit_q;
    logic [6:0]    sh_q;
    logic          half_end;
    logic          byte_end;

    assign half_end = active_q && (div_q == DW'(CLK_DIV - 1));
    assign byte_end = half_end && sck_q && (bit_q == 3'd7);
    // Idle is reported during the final half-period so a following byte can start seamlessly.
    assign idle     = !active_q || byte_end;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            div_q    <= '0;
            bit_q    <= 3'd0;
        end else if (load && idle) begin
            active_q <= 1'b1;
            sck_q    <= 1'b0;
            mosi_q   <= data[7];
            div_q    <= '0;
            bit_q    <= 3'd0;
        end else if (byte_end) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            div_q    <= '0;
        end else if (half_end) begin
            div_q <= '0;
            sck_q <= !sck_q;
            if (sck_q) begin
                bit_q  <= bit_q + 3'd1;
                mosi_q <= sh_q[6];
            end
        end else if (active_q) begin
            div_q <= div_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load && idle) begin
            sh_q <= data[6:0];
        end else if (half_end && sck_q) begin
            sh_q <= {sh_q[5:0], 1'b0};
        end
    end

    assign sck  = sck_q;
    assign mosi = mosi_q;

endmodule

// File: rtl/dataio_spi_master.sv
// data_io download initiator: index select, start, payload burst and end transfers over SPI_SS2.
module dataio_spi_master
    import dataio_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] index,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_last,
    output logic       din_ready,
    output logic       busy,
    output logic       done,
    output logic       spi_sck,
    output logic       spi_mosi,
    output logic       spi_ss_n
);

    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_e        state_q;
    state_e        ret_q;
    logic [CW-1:0] cnt_q;
    logic          sent_q;
    logic          hold_q;
    logic [7:0]    index_q;
    logic          ss_n_q;
    logic          busy_q;
    logic          done_q;
    logic          tx_idle;
    logic          tx_load;
    logic [7:0]    tx_data;

    always_comb begin
        tx_load   = 1'b0;
        tx_data   = 8'h00;
        din_ready = 1'b0;
        case (state_q)
            ST_SEL1, ST_SEL2, ST_SEL3, ST_SEL4: begin
                tx_load = (cnt_q == CW'(CLK_DIV - 1));
                tx_data = sel_cmd(state_q);
            end
            ST_IDX: begin
                tx_load = !sent_q && tx_idle;
                tx_data = index_q;
            end
            ST_STA: begin
                tx_load = !sent_q && tx_idle;
                tx_data = ARG_START;
            end
            ST_END: begin
                tx_load = !sent_q && tx_idle;
                tx_data = ARG_END;
            end
            ST_DAT: begin
                din_ready = !sent_q && tx_idle && din_valid;
                tx_load   = din_ready;
                tx_data   = din;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_SEL2;
            cnt_q   <= '0;
            sent_q  <= 1'b0;
            hold_q  <= 1'b0;
            ss_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // A start coinciding with the done pulse is deliberately dropped.
                ST_IDLE: begin
                    if (start && !done_q) begin
                        busy_q  <= 1'b1;
                        ss_n_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_SEL1;
                    end
                end
                ST_SEL1, ST_SEL2, ST_SEL3, ST_SEL4: begin
                    if (tx_load) begin
                        cnt_q   <= '0;
                        sent_q  <= 1'b0;
                        hold_q  <= 1'b0;
                        state_q <= sel_next(state_q);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_IDX, ST_STA, ST_DAT, ST_END: begin
                    if (hold_q) begin
                        if (cnt_q == CW'(CLK_DIV - 1)) begin
                            ss_n_q  <= 1'b1;
                            cnt_q   <= '0;
                            hold_q  <= 1'b0;
                            ret_q   <= gap_next(state_q);
                            state_q <= (state_q == ST_END) ? ST_DONE : ST_GAP;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else if (sent_q && tx_idle) begin
                        hold_q <= 1'b1;
                        cnt_q  <= '0;
                    end else if (tx_load && (state_q != ST_DAT || din_last)) begin
                        sent_q <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        ss_n_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ret_q;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && start && !done_q) begin
            index_q <= index;
        end
    end

    spi_byte_tx #(
        .CLK_DIV(CLK_DIV)
    ) u_tx (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (tx_load),
        .data   (tx_data),
        .sck    (spi_sck),
        .mosi   (spi_mosi),
        .idle   (tx_idle)
    );

    assign spi_ss_n = ss_n_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
